// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: one-hot grants, address/data-phase muxing onto the
// single bridge slave port, and a hold counter bounding one owner's burst length.
module ahb_arbiter #(
  parameter int N        = 4,
  parameter int MW       = 2,
  parameter int MAX_HOLD = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic [N-1:0]      hbusreq,
  input  logic [2*N-1:0]    htrans_m,
  input  logic [32*N-1:0]   haddr_m,
  input  logic [N-1:0]      hwrite_m,
  input  logic [32*N-1:0]   hwdata_m,
  output logic [N-1:0]      hgrant,
  output logic [MW-1:0]     hmaster,
  output logic [1:0]        htrans,
  output logic [31:0]       haddr,
  output logic              hwrite,
  output logic [31:0]       hwdata,
  output logic              hready_in,
  input  logic              hreadyout,
  input  logic [1:0]        hresp_s,
  input  logic [31:0]       hrdata_s,
  output logic              hready,
  output logic [1:0]        hresp,
  output logic [31:0]       hrdata
);

  // Handshake: every transfer phase (address, data, arbitration) advances
  // only on a rising edge where hreadyout=1; hreadyout=0 freezes all arbiter state.

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OWNED = 1'b1;
  localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);

  logic [0:0]    state_q, state_d;
  logic [N-1:0]  hgrant_q, hgrant_d;
  logic [MW-1:0] hmaster_q, hmaster_d;
  logic [MW-1:0] hmaster_dp_q, hmaster_dp_d;
  logic [MW-1:0] last_q, last_d;
  logic [7:0]    hold_q, hold_d;

  logic [1:0]    owner_trans;
  logic [31:0]   owner_addr;
  logic          owner_write;
  logic [31:0]   dp_wdata;
  logic          owner_req;
  logic          others_req;
  logic          owner_active;
  logic [7:0]    hold_inc;
  logic          arb_evt;
  logic          found;
  logic [MW-1:0] win;
  int            idx;

  always_comb begin
    owner_trans = 2'b00;
    owner_addr  = haddr_m[31:0];
    owner_write = hwrite_m[0];
    dp_wdata    = hwdata_m[31:0];
    for (int i = 0; i < N; i++) begin
      if (hmaster_q == MW'(i)) begin
        owner_trans = htrans_m[2*i +: 2];
        owner_addr  = haddr_m[32*i +: 32];
        owner_write = hwrite_m[i];
      end
      if (hmaster_dp_q == MW'(i)) begin
        dp_wdata = hwdata_m[32*i +: 32];
      end
    end
  end

  // The counter includes the phase accepted on this edge, so a forced
  // handover happens right after the MAX_HOLD-th accepted address phase.
  always_comb begin
    owner_req    = |(hbusreq & hgrant_q);
    others_req   = |(hbusreq & ~hgrant_q);
    owner_active = (state_q == ST_OWNED) && owner_trans[1];
    hold_inc     = (owner_active && (hold_q != HOLD_MAX)) ? hold_q + 8'd1 : hold_q;
    arb_evt      = hreadyout && ((state_q == ST_IDLE) || !owner_req ||
                                 ((hold_inc == HOLD_MAX) && others_req));
  end

  // Rotating search starting just after the last winner; the previous owner
  // comes last, so it only re-wins when nobody else is requesting.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && hbusreq[idx]) begin
        found = 1'b1;
        win   = MW'(idx);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    hgrant_d     = hgrant_q;
    hmaster_d    = hmaster_q;
    last_d       = last_q;
    hold_d       = hold_q;
    hmaster_dp_d = hreadyout ? hmaster_q : hmaster_dp_q;
    if (arb_evt) begin
      hold_d = 8'd0;
      if (found) begin
        state_d   = ST_OWNED;
        hgrant_d  = N'(1) << win;
        hmaster_d = win;
        last_d    = win;
      end else begin
        state_d  = ST_IDLE;
        hgrant_d = '0;
      end
    end else if (hreadyout) begin
      hold_d = hold_inc;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q      <= ST_IDLE;
      hgrant_q     <= '0;
      hmaster_q    <= '0;
      hmaster_dp_q <= '0;
      last_q       <= MW'(N-1);
      hold_q       <= 8'd0;
    end else begin
      state_q      <= state_d;
      hgrant_q     <= hgrant_d;
      hmaster_q    <= hmaster_d;
      hmaster_dp_q <= hmaster_dp_d;
      last_q       <= last_d;
      hold_q       <= hold_d;
    end
  end

  assign hgrant    = hgrant_q;
  assign hmaster   = hmaster_q;
  assign htrans    = (state_q == ST_OWNED) ? owner_trans : 2'b00;
  assign haddr     = owner_addr;
  assign hwrite    = owner_write;
  assign hwdata    = dp_wdata;
  assign hready_in = hreadyout;
  assign hready    = hreadyout;
  assign hresp     = hresp_s;
  assign hrdata    = hrdata_s;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Directed bench for ahb_arbiter: reset, round robin, release, wait states,
// hold saturation, response pass-through and reset mid-burst.
module tb_ahb_arbiter;

  localparam int N  = 4;
  localparam int MW = 2;

  logic            hclk = 1'b0;
  logic            hreset;
  logic [N-1:0]    hbusreq;
  logic [2*N-1:0]  htrans_m;
  logic [32*N-1:0] haddr_m;
  logic [N-1:0]    hwrite_m;
  logic [32*N-1:0] hwdata_m;
  logic            hreadyout;
  logic [1:0]      hresp_s;
  logic [31:0]     hrdata_s;

  logic [N-1:0]    hgrant, hgrant8;
  logic [MW-1:0]   hmaster, hmaster8;
  logic [1:0]      htrans, htrans8;
  logic [31:0]     haddr, haddr8;
  logic            hwrite, hwrite8;
  logic [31:0]     hwdata, hwdata8;
  logic            hready_in, hready_in8;
  logic            hready, hready8;
  logic [1:0]      hresp, hresp8;
  logic [31:0]     hrdata, hrdata8;

  int n_checks = 0;
  int n_pass   = 0;
  logic [MW-1:0] exp_q[$];

  ahb_arbiter #(.N(N), .MW(MW), .MAX_HOLD(2)) u_dut (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .htrans_m(htrans_m),
    .haddr_m(haddr_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m),
    .hgrant(hgrant), .hmaster(hmaster), .htrans(htrans), .haddr(haddr),
    .hwrite(hwrite), .hwdata(hwdata), .hready_in(hready_in),
    .hreadyout(hreadyout), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  ahb_arbiter #(.N(N), .MW(MW), .MAX_HOLD(8)) u_dut8 (
    .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .htrans_m(htrans_m),
    .haddr_m(haddr_m), .hwrite_m(hwrite_m), .hwdata_m(hwdata_m),
    .hgrant(hgrant8), .hmaster(hmaster8), .htrans(htrans8), .haddr(haddr8),
    .hwrite(hwrite8), .hwdata(hwdata8), .hready_in(hready_in8),
    .hreadyout(hreadyout), .hresp_s(hresp_s), .hrdata_s(hrdata_s),
    .hready(hready8), .hresp(hresp8), .hrdata(hrdata8)
  );

  // Clock
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge hclk);
    #2;
  endtask

  task automatic set_m(input int i, input logic [1:0] tr);
    htrans_m[2*i +: 2] = tr;
  endtask

  function automatic logic [31:0] wdata_of(input int i);
    return 32'hD000_0000 | i;
  endfunction

  initial begin
    logic [MW-1:0] exp_m;
    logic [MW-1:0] prev_m;
    int k;

    // Reset with all masters requesting
    hreset    = 1'b1;
    hbusreq   = 4'b1111;
    htrans_m  = 8'b10_10_10_10;
    hwrite_m  = 4'b0000;
    hreadyout = 1'b1;
    hresp_s   = 2'b00;
    hrdata_s  = 32'h0;
    for (int i = 0; i < N; i++) begin
      haddr_m[32*i +: 32]  = 32'hA000_0000 | i;
      hwdata_m[32*i +: 32] = wdata_of(i);
    end
    tick();
    check("rst_grant", 32'(hgrant), 32'h0);
    check("rst_htrans", 32'(htrans), 32'h0);
    check("rst_hmaster", 32'(hmaster), 32'h0);
    check("rst_haddr", haddr, 32'hA000_0000);
    check("rst_hwdata", hwdata, 32'hD000_0000);
    tick();
    check("rst_grant2", 32'(hgrant), 32'h0);
    hreset = 1'b0;
    tick();
    check("first_grant", 32'(hgrant), 32'h1);
    check("first_htrans", 32'(htrans), 32'h2);
    check("first_haddr", haddr, 32'hA000_0000);

    // Round robin with MAX_HOLD=2: two accepted phases per owner
    exp_q = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    prev_m = 2'd0;
    k = 0;
    while (exp_q.size() > 0) begin
      exp_m = exp_q.pop_front();
      tick();
      check("rr_grant", 32'(hgrant), 32'(4'b0001 << exp_m));
      check("rr_hwdata", hwdata, wdata_of(int'(prev_m)));
      check("rr_grant_h8", 32'(hgrant8), (k == 7) ? 32'h2 : 32'h1);
      prev_m = exp_m;
      k++;
    end

    // Master 2 alone: one write, then release
    hbusreq  = 4'b0100;
    htrans_m = 8'b00_10_00_00;
    haddr_m[64 +: 32]  = 32'h8000_0010;
    hwdata_m[64 +: 32] = 32'hA5A5_A5A5;
    hwrite_m = 4'b0100;
    tick();
    check("rel_grant", 32'(hgrant), 32'h4);
    check("rel_haddr", haddr, 32'h8000_0010);
    check("rel_hwrite", 32'(hwrite), 32'h1);
    check("rel_hwdata_early", hwdata, 32'hD000_0000);
    tick();
    check("rel_hmaster_dp", 32'(hmaster), 32'h2);
    check("rel_hwdata", hwdata, 32'hA5A5_A5A5);
    hbusreq = 4'b0000;
    set_m(2, 2'b00);
    tick();
    check("rel_idle_grant", 32'(hgrant), 32'h0);
    check("rel_idle_htrans", 32'(htrans), 32'h0);
    check("rel_hold_hmaster", 32'(hmaster), 32'h2);

    // Wait states freeze the grant even though the owner drops
    hbusreq = 4'b0010;
    set_m(1, 2'b10);
    tick();
    check("ws_grant_m1", 32'(hgrant), 32'h2);
    hbusreq   = 4'b1000;
    set_m(3, 2'b10);
    hreadyout = 1'b0;
    #1;
    check("ws_hready", 32'(hready), 32'h0);
    check("ws_hready_in", 32'(hready_in), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("ws_frozen", 32'(hgrant), 32'h2);
    end
    hreadyout = 1'b1;
    tick();
    check("ws_switch", 32'(hgrant), 32'h8);

    // Master 0 alone, 20 transfers: grant never drops
    hbusreq  = 4'b0001;
    htrans_m = 8'b00_00_00_10;
    tick();
    check("sat_grant0", 32'(hgrant), 32'h1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("sat_keep", 32'(hgrant), 32'h1);
      check("sat_keep_h8", 32'(hgrant8), 32'h1);
    end
    // Saturated counter hands over on the first edge master 1 requests
    hbusreq = 4'b0011;
    set_m(1, 2'b10);
    tick();
    check("sat_handover", 32'(hgrant), 32'h2);
    check("sat_handover_h8", 32'(hgrant8), 32'h2);

    // Response pass-through, then reset mid-burst
    hresp_s  = 2'b01;
    hrdata_s = 32'h1234_5678;
    #1;
    check("pt_hresp", 32'(hresp), 32'h1);
    check("pt_hrdata", hrdata, 32'h1234_5678);
    check("pt_hready", 32'(hready), 32'h1);
    tick();
    check("pt_grant", 32'(hgrant), 32'h2);
    hreset    = 1'b1;
    hreadyout = 1'b0;
    tick();
    check("midrst_grant", 32'(hgrant), 32'h0);
    check("midrst_htrans", 32'(htrans), 32'h0);
    check("midrst_hmaster", 32'(hmaster), 32'h0);
    hreset    = 1'b0;
    hreadyout = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
